// File: rtl/pkg_lobinho.sv
// rtl/pkg_lobinho.sv - shared parameters and state encoding for the werewolf game datapath
package pkg_lobinho;

    localparam int N_JOG_PADRAO = 8;
    localparam int W_JOG_PADRAO = 3;

    // Codes are also decoded by the 7-seg debug display, keep them stable
    localparam logic [3:0] COD_OCIOSO      = 4'd0;
    localparam logic [3:0] COD_ZERA        = 4'd1;
    localparam logic [3:0] COD_PROCURA     = 4'd2;
    localparam logic [3:0] COD_ESPERA_VOTO = 4'd3;
    localparam logic [3:0] COD_REGISTRA    = 4'd4;
    localparam logic [3:0] COD_AVANCA      = 4'd5;
    localparam logic [3:0] COD_APURA       = 4'd6;
    localparam logic [3:0] COD_RESULTADO   = 4'd7;
    localparam logic [3:0] COD_INVALIDO    = 4'hF;

    typedef enum logic [3:0] {
        OCIOSO      = COD_OCIOSO,
        ZERA        = COD_ZERA,
        PROCURA     = COD_PROCURA,
        ESPERA_VOTO = COD_ESPERA_VOTO,
        REGISTRA    = COD_REGISTRA,
        AVANCA      = COD_AVANCA,
        APURA       = COD_APURA,
        RESULTADO   = COD_RESULTADO
    } estado_t;

endpackage

// File: rtl/controle_votacao_dia_if.sv
// rtl/controle_votacao_dia_if.sv - control/vote/result signals between the main control unit and the day vote scheduler
interface votacao_if
    import pkg_lobinho::*;
#(
    parameter int N_JOG = N_JOG_PADRAO,
    parameter int W_JOG = W_JOG_PADRAO
);
    logic             iniciar;
    logic [N_JOG-1:0] vivos;
    logic             passa;
    logic [W_JOG-1:0] alvo;
    logic [W_JOG-1:0] jogador_atual;
    logic             espera_voto;
    logic             erro_voto;
    logic [W_JOG-1:0] eliminado;
    logic             houve_eliminacao;
    logic             empate;
    logic             fim;
    logic [3:0]       db_estado;

    modport master (
        output iniciar, vivos, passa, alvo,
        input  jogador_atual, espera_voto, erro_voto, eliminado,
               houve_eliminacao, empate, fim, db_estado
    );

    modport slave (
        input  iniciar, vivos, passa, alvo,
        output jogador_atual, espera_voto, erro_voto, eliminado,
               houve_eliminacao, empate, fim, db_estado
    );
endinterface

// File: rtl/contador_votos.sv
// rtl/contador_votos.sv - per-player vote tally with clear, increment-by-index and indexed read
module contador_votos #(
    parameter int N_JOG = 8,
    parameter int W_JOG = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             limpa,
    input  logic             incrementa,
    input  logic [W_JOG-1:0] indice_inc,
    input  logic [W_JOG-1:0] indice_leitura,
    output logic [W_JOG:0]   valor
);
    // One extra bit: a player can receive at most N_JOG votes
    logic [W_JOG:0] cont [N_JOG];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_JOG; i++) cont[i] <= '0;
        end else if (limpa) begin
            for (int i = 0; i < N_JOG; i++) cont[i] <= '0;
        end else if (incrementa) begin
            cont[indice_inc] <= cont[indice_inc] + (W_JOG+1)'(1);
        end
    end

    assign valor = cont[indice_leitura];

endmodule

// File: rtl/controle_votacao_dia.sv
// rtl/controle_votacao_dia.sv - day-phase vote scheduler: collects one vote per living player and finds the unique maximum
module controle_votacao_dia
    import pkg_lobinho::*;
#(
    parameter int N_JOG = N_JOG_PADRAO,
    parameter int W_JOG = W_JOG_PADRAO
) (
    input logic     clock,
    input logic     reset,
    votacao_if.slave bus
);
    estado_t          estado, proximo;
    logic [W_JOG-1:0] idx, prox_idx, alvo_r, cand, cand_n, eliminado_r;
    logic [N_JOG-1:0] vivos_r;
    logic [W_JOG:0]   max_r, max_n, cont_rd;
    logic             empate_r, empate_n, erro_voto_r, houve_r, empate_o;
    logic             ultimo, alvo_invalido, maior, igual;

    contador_votos #(.N_JOG(N_JOG), .W_JOG(W_JOG)) u_contador (
        .clock          (clock),
        .reset          (reset),
        .limpa          (estado == ZERA),
        .incrementa     (estado == REGISTRA),
        .indice_inc     (alvo_r),
        .indice_leitura (idx),
        .valor          (cont_rd)
    );

    assign ultimo        = (idx == W_JOG'(N_JOG - 1));
    assign prox_idx      = ultimo ? '0 : idx + W_JOG'(1);
    assign alvo_invalido = ({1'b0, bus.alvo} >= (W_JOG+1)'(N_JOG)) || !vivos_r[bus.alvo];

    // Scan step: a strictly larger tally takes over and clears any pending tie
    assign maior    = (cont_rd > max_r);
    assign igual    = (cont_rd == max_r) && (max_r != '0);
    assign max_n    = maior ? cont_rd : max_r;
    assign cand_n   = maior ? idx : cand;
    assign empate_n = maior ? 1'b0 : (igual ? 1'b1 : empate_r);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    always_comb begin
        proximo         = estado;
        bus.espera_voto = 1'b0;
        bus.fim         = 1'b0;
        bus.db_estado   = estado;
        case (estado)
            OCIOSO:      if (bus.iniciar) proximo = ZERA;
            ZERA:        proximo = PROCURA;
            PROCURA: begin
                if (vivos_r[idx]) proximo = ESPERA_VOTO;
                else if (ultimo)  proximo = APURA;
            end
            ESPERA_VOTO: begin
                bus.espera_voto = 1'b1;
                if (bus.passa && !alvo_invalido) proximo = REGISTRA;
            end
            REGISTRA:    proximo = AVANCA;
            AVANCA:      proximo = ultimo ? APURA : PROCURA;
            APURA:       if (ultimo) proximo = RESULTADO;
            RESULTADO: begin
                bus.fim = 1'b1;
                if (bus.iniciar) proximo = ZERA;
            end
            default: begin
                proximo       = OCIOSO;
                bus.db_estado = COD_INVALIDO;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            vivos_r     <= '0;
            alvo_r      <= '0;
            max_r       <= '0;
            cand        <= '0;
            empate_r    <= 1'b0;
            erro_voto_r <= 1'b0;
            eliminado_r <= '0;
            houve_r     <= 1'b0;
            empate_o    <= 1'b0;
        end else begin
            erro_voto_r <= 1'b0;
            case (estado)
                OCIOSO, RESULTADO: if (bus.iniciar) vivos_r <= bus.vivos;
                ZERA: begin
                    idx         <= '0;
                    max_r       <= '0;
                    cand        <= '0;
                    empate_r    <= 1'b0;
                    eliminado_r <= '0;
                    houve_r     <= 1'b0;
                    empate_o    <= 1'b0;
                end
                PROCURA: if (!vivos_r[idx]) idx <= prox_idx;
                ESPERA_VOTO: if (bus.passa) begin
                    alvo_r      <= bus.alvo;
                    erro_voto_r <= alvo_invalido;
                end
                AVANCA: idx <= prox_idx;
                APURA: begin
                    max_r    <= max_n;
                    cand     <= cand_n;
                    empate_r <= empate_n;
                    idx      <= prox_idx;
                    // Zero maximum means nobody voted: reported as a tie
                    if (ultimo) begin
                        if (max_n == '0 || empate_n) begin
                            houve_r  <= 1'b0;
                            empate_o <= 1'b1;
                        end else begin
                            houve_r     <= 1'b1;
                            eliminado_r <= cand_n;
                            empate_o    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.jogador_atual    = idx;
    assign bus.erro_voto        = erro_voto_r;
    assign bus.eliminado        = eliminado_r;
    assign bus.houve_eliminacao = houve_r;
    assign bus.empate           = empate_o;

endmodule

// File: doc/controle_votacao_dia.md
Name: controle_votacao_dia

Overview:
Day-phase vote scheduler for the werewolf game datapath. The block steps through each living player in index order and accepts one vote per player, confirmed with the `passa` button. It tallies the votes in per-player counters, scans the tallies for a unique maximum, and reports the eliminated player or a tie. The main control unit starts it after the night announcement and reads `fim` and the result outputs.

Parameters:
- N_JOG, 8, number of players (2..16)
- W_JOG, 3, player index width = clog2(N_JOG)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  one-cycle pulse; starts a voting round
- vivos  in  N_JOG  alive mask, bit i = player i alive; sampled on iniciar
- passa  in  1  one-cycle pulse; confirms the current vote
- alvo  in  W_JOG  target index selected by the current voter
- jogador_atual  out  W_JOG  index of the player voting now
- espera_voto  out  1  high while waiting for `passa`
- erro_voto  out  1  one-cycle pulse; vote rejected
- eliminado  out  W_JOG  eliminated index, valid when houve_eliminacao=1
- houve_eliminacao  out  1  unique maximum found with at least 1 vote
- empate  out  1  two or more players share the maximum, or no votes were cast
- fim  out  1  high in RESULTADO; round finished
- db_estado  out  4  current state code

Behaviour:
- States and codes:
  - OCIOSO=0, ZERA=1, PROCURA=2, ESPERA_VOTO=3, REGISTRA=4, AVANCA=5, APURA=6, RESULTADO=7
  - Any other code: return to OCIOSO; db_estado=4'hF.
- Reset (async): state=OCIOSO. All tally counters, idx, max, eliminado, jogador_atual = 0. All flags = 0.
- OCIOSO:
  - iniciar=1 -> ZERA. Latch `vivos` into vivos_r on this same edge.
- ZERA:
  - Clear all counters, idx=0, max=0, empate_r=0, result flags = 0.
  - -> PROCURA.
- PROCURA (one index per cycle):
  - vivos_r[idx]=1 -> ESPERA_VOTO.
  - Else if idx==N_JOG-1 -> APURA with idx=0.
  - Else idx+1, stay in PROCURA.
- ESPERA_VOTO:
  - espera_voto=1, jogador_atual=idx.
  - passa=1 and (alvo>=N_JOG or vivos_r[alvo]=0): erro_voto=1 in the next cycle, stay in ESPERA_VOTO.
  - passa=1 and target valid: -> REGISTRA.
  - Self-vote is permitted.
- REGISTRA:
  - cont[alvo_r] += 1, where alvo_r is alvo registered on the passa edge.
  - Counter width W_JOG+1; it cannot overflow because votes <= N_JOG.
  - -> AVANCA.
- AVANCA:
  - idx==N_JOG-1 -> APURA with idx=0.
  - Else idx+1 -> PROCURA.
- APURA (exactly N_JOG cycles, one counter per cycle):
  - cont[idx] > max: max=cont[idx], cand=idx, empate_r=0.
  - cont[idx]==max and max!=0: empate_r=1.
  - After idx==N_JOG-1 -> RESULTADO.
- RESULTADO:
  - max==0 (no living voters): houve_eliminacao=0, empate=1.
  - Else if empate_r: houve_eliminacao=0, empate=1.
  - Else: houve_eliminacao=1, eliminado=cand, empate=0.
  - fim=1. Results hold until the next iniciar, which restarts at ZERA.
- Outputs are registered. fim, espera_voto and db_estado decode directly from the state register.
- passa outside ESPERA_VOTO is ignored.
- iniciar outside OCIOSO/RESULTADO is ignored.
- Simultaneous iniciar and passa in RESULTADO: iniciar wins.
- Latency, all living, N_JOG=8:
  - iniciar -> first espera_voto: 2 cycles.
  - Each accepted vote -> next espera_voto: 3 cycles, plus 1 per skipped dead player.
  - Last vote -> fim: N_JOG+2 cycles.
- Reset mid-round: abort to OCIOSO; the partial tally is discarded.

Decomposition:
- Shared package pkg_lobinho holds:
  - the state encoding localparams (shared with the db_estado decoder on the 7-seg display);
  - N_JOG/W_JOG defaults.
- Sub-module contador_votos: N_JOG counters with synchronous clear, increment-by-index, and read mux by index.
- The FSM, scan and compare logic stay in the top module.

Test Plan:
1. All alive. Votes 0..7 -> alvo 3,3,3,1,1,2,5,3. Required: fim=1, houve_eliminacao=1, eliminado=3, empate=0.
2. vivos=8'b1010_1010. Required: jogador_atual sequence is 1,3,5,7 only. Votes 7,7,5,7 -> eliminado=7.
3. All alive, votes 0,0,0,0,1,1,1,1 -> empate=1, houve_eliminacao=0.
4. Player 0 votes alvo=2 while vivos[2]=0. Required: erro_voto pulses, state stays ESPERA_VOTO, no count. A valid alvo then advances.
5. vivos=0 -> fim after N_JOG+N_JOG+2 cycles, empate=1, houve_eliminacao=0.
6. Assert reset during ESPERA_VOTO for player 4. Required: db_estado=0 and all outputs 0 immediately. Then a new round with all votes on 6 -> eliminado=6.
